// File: rtl/i2c_temp_slave_if.sv
// ----------------------------------------------------------------------------
// i2c_temp_slave_if
// Purpose : Two-wire I2C bus bundle for the temperature-sensor responder.
//           SDA is open-drain. Each side can only pull the line low or let it
//           go. The bus level is the wired-AND of both sides over a pull-up.
// Signals :
//   scl        - clock, driven by the master
//   sda_pull_m - master pulls SDA low when 1
//   sda_pull_s - slave pulls SDA low when 1 (0 = released, i.e. z)
//   sda        - resolved SDA line level seen by both sides
// Modports: master (drives scl/sda_pull_m), slave (drives sda_pull_s)
// ----------------------------------------------------------------------------
interface i2c_temp_slave_if;
   logic scl;
   logic sda_pull_m;
   logic sda_pull_s;
   wire  sda;

   // Pull-up: the line is high unless someone pulls it low.
   assign sda = ~(sda_pull_m | sda_pull_s);

   modport master (output scl, output sda_pull_m, input sda);
   modport slave  (input scl, output sda_pull_s, input sda);
endinterface

// File: rtl/i2c_temp_slave.sv
// ----------------------------------------------------------------------------
// i2c_temp_slave
// Purpose : I2C responder that models the read path of an LM75A-style
//           temperature sensor. It answers a 2-byte read from the preset
//           pointer: it ACKs address+R, then sends the MSB and LSB of a
//           16-bit temperature word. The word wraps back to the MSB while the
//           master keeps ACKing.
// Ports   :
//   clk        in   system clock (50 MHz)
//   rst_n      in   asynchronous reset, active-low
//   bus        if   I2C bus (slave modport): scl in, sda open-drain
//   temp       in   temperature word, [15:8] MSB byte, [7:0] LSB byte
//   busy       out  high from accepted START until STOP/abort
//   addr_hit   out  1-cycle pulse on address+R match
//   xfer_done  out  1-cycle pulse when the master NACKs a data byte
// ----------------------------------------------------------------------------
module i2c_temp_slave #(
   parameter logic [6:0]  DEV_ADDR = 7'b1001000,
   parameter int unsigned FILT_LEN = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   i2c_temp_slave_if.slave bus,
   input  logic [15:0]     temp,
   output logic            busy,
   output logic            addr_hit,
   output logic            xfer_done
);

   localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILT_LEN - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StTxByte,
      StTxAck,
      StWaitStop
   } state_e;

   // ---------------------------------------------------------------------
   // Input path: 2-FF synchroniser, then a glitch filter. The filtered level
   // only follows the synchronised input after FILT_LEN consecutive samples
   // that differ from it. Any sample equal to the current level restarts the
   // count.
   // ---------------------------------------------------------------------
   logic [1:0]       r_scl_sync, r_sda_sync;
   logic [CNT_W-1:0] r_scl_cnt, r_sda_cnt;
   logic             r_scl_filt, r_sda_filt;
   logic             r_scl_prev, r_sda_prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_cnt  <= '0;
         r_sda_cnt  <= '0;
         r_scl_filt <= 1'b1;
         r_sda_filt <= 1'b1;
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], bus.scl};
         r_sda_sync <= {r_sda_sync[0], bus.sda};
         r_scl_prev <= r_scl_filt;
         r_sda_prev <= r_sda_filt;

         if (r_scl_sync[1] == r_scl_filt) begin
            r_scl_cnt <= '0;
         end else if (r_scl_cnt == CNT_MAX) begin
            r_scl_filt <= r_scl_sync[1];
            r_scl_cnt  <= '0;
         end else begin
            r_scl_cnt <= r_scl_cnt + 1'b1;
         end

         if (r_sda_sync[1] == r_sda_filt) begin
            r_sda_cnt <= '0;
         end else if (r_sda_cnt == CNT_MAX) begin
            r_sda_filt <= r_sda_sync[1];
            r_sda_cnt  <= '0;
         end else begin
            r_sda_cnt <= r_sda_cnt + 1'b1;
         end
      end
   end

   logic w_scl_rise, w_scl_fall, w_start, w_stop;

   assign w_scl_rise = r_scl_filt & ~r_scl_prev;
   assign w_scl_fall = ~r_scl_filt & r_scl_prev;
   // SCL must be high both before and after the SDA edge. Our own SDA changes
   // always follow a detected SCL fall, so they can never look like START/STOP.
   assign w_start    = r_sda_prev & ~r_sda_filt & r_scl_filt & r_scl_prev;
   assign w_stop     = ~r_sda_prev & r_sda_filt & r_scl_filt & r_scl_prev;

   // ---------------------------------------------------------------------
   // Protocol FSM
   // ---------------------------------------------------------------------
   state_e      r_state, w_state_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic [2:0]  r_bit_cnt, w_bit_cnt_nxt;
   logic [15:0] r_snap, w_snap_nxt;
   logic        r_byte_sel, w_byte_sel_nxt;
   logic        r_ack_ok, w_ack_ok_nxt;
   logic        r_sda_oe, w_sda_oe_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_addr_hit, w_addr_hit_nxt;
   logic        r_xfer_done, w_xfer_done_nxt;

   logic [7:0]  w_addr_byte;
   logic [7:0]  w_next_byte;

   assign w_addr_byte = {r_shift[6:0], r_sda_filt};
   assign w_next_byte = r_byte_sel ? r_snap[7:0] : r_snap[15:8];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_shift     <= '0;
         r_bit_cnt   <= '0;
         r_snap      <= '0;
         r_byte_sel  <= 1'b0;
         r_ack_ok    <= 1'b0;
         r_sda_oe    <= 1'b0;
         r_busy      <= 1'b0;
         r_addr_hit  <= 1'b0;
         r_xfer_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_snap      <= w_snap_nxt;
         r_byte_sel  <= w_byte_sel_nxt;
         r_ack_ok    <= w_ack_ok_nxt;
         r_sda_oe    <= w_sda_oe_nxt;
         r_busy      <= w_busy_nxt;
         r_addr_hit  <= w_addr_hit_nxt;
         r_xfer_done <= w_xfer_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_snap_nxt      = r_snap;
      w_byte_sel_nxt  = r_byte_sel;
      w_ack_ok_nxt    = r_ack_ok;
      w_sda_oe_nxt    = r_sda_oe;
      w_busy_nxt      = r_busy;
      w_addr_hit_nxt  = 1'b0;
      w_xfer_done_nxt = 1'b0;

      if (w_stop) begin
         w_state_nxt   = StIdle;
         w_busy_nxt    = 1'b0;
         w_sda_oe_nxt  = 1'b0;
         w_bit_cnt_nxt = '0;
         w_ack_ok_nxt  = 1'b0;
      end else if (w_start) begin
         // A repeated START lands here as well, from any state.
         w_state_nxt   = StAddr;
         w_busy_nxt    = 1'b1;
         w_sda_oe_nxt  = 1'b0;
         w_bit_cnt_nxt = '0;
         w_shift_nxt   = '0;
         w_ack_ok_nxt  = 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               w_sda_oe_nxt = 1'b0;
            end

            StAddr: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_addr_byte;
                  if (r_bit_cnt == 3'd7) begin
                     w_bit_cnt_nxt = '0;
                     if (w_addr_byte == {DEV_ADDR, 1'b1}) begin
                        w_addr_hit_nxt = 1'b1;
                        w_snap_nxt     = temp;
                        w_byte_sel_nxt = 1'b0;
                        w_state_nxt    = StAddrAck;
                     end else begin
                        w_state_nxt = StWaitStop;
                     end
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                  end
               end
            end

            // 1st fall (end of 8th clock): start the ACK. 2nd fall (end of
            // the 9th clock): put the MSB's first bit on the line.
            StAddrAck: begin
               if (w_scl_fall) begin
                  if (!r_sda_oe) begin
                     w_sda_oe_nxt = 1'b1;
                  end else begin
                     w_shift_nxt   = r_snap[15:8];
                     w_bit_cnt_nxt = '0;
                     w_sda_oe_nxt  = ~r_snap[15];
                     w_state_nxt   = StTxByte;
                  end
               end
            end

            StTxByte: begin
               if (w_scl_fall) begin
                  if (r_bit_cnt == 3'd7) begin
                     w_sda_oe_nxt  = 1'b0;
                     w_bit_cnt_nxt = '0;
                     w_ack_ok_nxt  = 1'b0;
                     w_state_nxt   = StTxAck;
                  end else begin
                     // Rotate left. The wrapped bit is never sent.
                     w_shift_nxt   = {r_shift[6:0], r_shift[7]};
                     w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                     w_sda_oe_nxt  = ~r_shift[6];
                  end
               end
            end

            StTxAck: begin
               if (w_scl_rise) begin
                  if (!r_sda_filt) begin
                     w_ack_ok_nxt   = 1'b1;
                     w_byte_sel_nxt = ~r_byte_sel;
                  end else begin
                     w_xfer_done_nxt = 1'b1;
                     w_state_nxt     = StWaitStop;
                  end
               end else if (w_scl_fall && r_ack_ok) begin
                  w_shift_nxt   = w_next_byte;
                  w_bit_cnt_nxt = '0;
                  w_sda_oe_nxt  = ~w_next_byte[7];
                  w_ack_ok_nxt  = 1'b0;
                  w_state_nxt   = StTxByte;
               end
            end

            StWaitStop: begin
               w_sda_oe_nxt = 1'b0;
            end

            default: begin
               w_state_nxt  = StIdle;
               w_sda_oe_nxt = 1'b0;
            end
         endcase
      end
   end

   assign bus.sda_pull_s = r_sda_oe;
   assign busy           = r_busy;
   assign addr_hit       = r_addr_hit;
   assign xfer_done      = r_xfer_done;

endmodule

// File: tb/tb_i2c_temp_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_temp_slave
// Bit-banged I2C master against i2c_temp_slave. Expected data bytes are queued
// when a read transaction starts, and are popped and compared as each byte
// comes back off the bus.
// ----------------------------------------------------------------------------
module tb_i2c_temp_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] temp;
   logic        busy, addr_hit, xfer_done;

   i2c_temp_slave_if bus ();

   i2c_temp_slave #(
      .DEV_ADDR(7'b1001000),
      .FILT_LEN(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .temp     (temp),
      .busy     (busy),
      .addr_hit (addr_hit),
      .xfer_done(xfer_done)
   );

   always #10 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         half;
   bit         glitch;
   logic [7:0] exp_q[$];

   // Pulse and drive monitors
   int n_hit  = 0;
   int n_done = 0;
   bit coincide = 1'b0;
   bit slv_drove = 1'b0;

   always @(posedge clk) begin
      if (addr_hit === 1'b1) n_hit++;
      if (xfer_done === 1'b1) n_done++;
      if (addr_hit === 1'b1 && xfer_done === 1'b1) coincide = 1'b1;
      if (bus.sda_pull_s === 1'b1) slv_drove = 1'b1;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Remainder of a low phase. Optionally hides a 1-clk SCL glitch in it.
   task automatic low_wait();
      if (glitch) begin
         wait_clk(3);
         bus.scl = 1'b1;
         wait_clk(1);
         bus.scl = 1'b0;
         wait_clk(half / 2 - 4);
      end else begin
         wait_clk(half / 2);
      end
   endtask

   // Every bus task ends a quarter period into an SCL low phase. The
   // exceptions are bus_stop, which leaves the bus idle, and bus_start, which
   // expects an idle bus.
   task automatic bus_start();
      bus.sda_pull_m = 1'b1;
      wait_clk(half);
      bus.scl = 1'b0;
      wait_clk(half / 2);
   endtask

   task automatic bus_rep_start();
      bus.sda_pull_m = 1'b0;
      wait_clk(half / 2);
      bus.scl = 1'b1;
      wait_clk(half);
      bus.sda_pull_m = 1'b1;
      wait_clk(half);
      bus.scl = 1'b0;
      wait_clk(half / 2);
   endtask

   task automatic bus_stop();
      bus.sda_pull_m = 1'b1;
      wait_clk(half / 2);
      bus.scl = 1'b1;
      wait_clk(half);
      bus.sda_pull_m = 1'b0;
      wait_clk(half);
   endtask

   task automatic write_bit(input bit b);
      bus.sda_pull_m = ~b;
      low_wait();
      bus.scl = 1'b1;
      if (glitch) begin
         // 1-clk SDA flip while SCL is high would otherwise be a START/STOP.
         wait_clk(half / 2);
         bus.sda_pull_m = ~bus.sda_pull_m;
         wait_clk(1);
         bus.sda_pull_m = ~bus.sda_pull_m;
         wait_clk(half - half / 2 - 1);
      end else begin
         wait_clk(half);
      end
      bus.scl = 1'b0;
      wait_clk(half / 2);
   endtask

   task automatic read_bit(output bit b);
      bus.sda_pull_m = 1'b0;
      low_wait();
      bus.scl = 1'b1;
      wait_clk(half / 2);
      b = bus.sda;
      wait_clk(half - half / 2);
      bus.scl = 1'b0;
      wait_clk(half / 2);
   endtask

   task automatic write_byte(input logic [7:0] v, output bit ack);
      for (int i = 7; i >= 0; i--) write_bit(v[i]);
      read_bit(ack);
   endtask

   task automatic read_byte(input bit m_ack, output logic [7:0] v);
      bit b;
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         v[i] = b;
      end
      write_bit(~m_ack);
   endtask

   task automatic read_check(input string tag, input bit m_ack);
      logic [7:0] v;
      logic [7:0] e;
      read_byte(m_ack, v);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      check_val(tag, v, e);
   endtask

   initial begin
      bit         ack;
      bit         b;
      int         h0, d0, lat;
      logic [2:0] part;

      bus.scl        = 1'b1;
      bus.sda_pull_m = 1'b0;
      temp           = 16'h1920;
      glitch         = 1'b0;
      half           = 100;                 // 250 kHz SCL at 50 MHz clk
      rst_n          = 1'b0;
      wait_clk(5);
      check_val("rst_busy", busy, 0);
      check_val("rst_addr_hit", addr_hit, 0);
      check_val("rst_xfer_done", xfer_done, 0);
      check_val("rst_sda", bus.sda_pull_s, 0);
      rst_n = 1'b1;
      wait_clk(10);

      // Basic read; temp changes after the MSB is ACKed.
      h0 = n_hit; d0 = n_done;
      exp_q.push_back(8'h19);
      exp_q.push_back(8'h20);
      bus_start();
      check_val("t1_busy", busy, 1);
      write_byte(8'h91, ack);
      check_val("t1_addr_ack", ack, 0);
      read_check("t1_msb", 1'b1);
      temp = 16'h0A80;
      read_check("t1_lsb", 1'b0);
      bus_stop();
      wait_clk(10);
      check_val("t1_busy_after", busy, 0);
      check_val("t1_hits", n_hit - h0, 1);
      check_val("t1_dones", n_done - d0, 1);

      // New snapshot; master ACKs LSB, so the MSB wraps.
      half = 25;
      h0 = n_hit; d0 = n_done;
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h0A);
      bus_start();
      write_byte(8'h91, ack);
      check_val("t2_addr_ack", ack, 0);
      read_check("t2_msb", 1'b1);
      read_check("t2_lsb", 1'b1);
      read_check("t2_wrap", 1'b0);
      bus_stop();
      wait_clk(10);
      check_val("t2_busy_after", busy, 0);
      check_val("t2_hits", n_hit - h0, 1);
      check_val("t2_dones", n_done - d0, 1);

      // Wrong address, then a write address: slave must never touch SDA.
      h0 = n_hit; d0 = n_done;
      slv_drove = 1'b0;
      bus_start();
      write_byte(8'h93, ack);
      check_val("t3_nack_93", ack, 1);
      check_val("t3_busy_93", busy, 1);
      bus_stop();
      wait_clk(10);
      check_val("t3_busy_off_93", busy, 0);
      bus_start();
      write_byte(8'h90, ack);
      check_val("t3_nack_90", ack, 1);
      write_byte(8'h55, ack);
      check_val("t3_nack_data", ack, 1);
      check_val("t3_busy_90", busy, 1);
      bus_stop();
      wait_clk(10);
      check_val("t3_busy_off_90", busy, 0);
      check_val("t3_sda_z", slv_drove, 0);
      check_val("t3_hits", n_hit - h0, 0);
      check_val("t3_dones", n_done - d0, 0);

      // STOP in the middle of the MSB, while bit 4 (a 1) is on the line.
      temp = 16'h1920;
      h0 = n_hit;
      bus_start();
      write_byte(8'h91, ack);
      check_val("t4_addr_ack", ack, 0);
      for (int i = 2; i >= 0; i--) begin
         read_bit(b);
         part[i] = b;
      end
      check_val("t4_partial", part, 3'(8'h19 >> 5));
      bus.sda_pull_m = 1'b1;
      wait_clk(half / 2);
      bus.scl = 1'b1;
      wait_clk(half);
      bus.sda_pull_m = 1'b0;
      lat = 0;
      while (busy === 1'b1 && lat < 20) begin
         wait_clk(1);
         lat++;
      end
      check_val("t4_stop_latency_ok", (lat <= 6), 1);
      check_val("t4_sda_released", bus.sda_pull_s, 0);
      wait_clk(half);

      // Repeated START after 4 address bits, then a full read.
      exp_q.push_back(8'h19);
      exp_q.push_back(8'h20);
      bus_start();
      write_bit(1'b1); write_bit(1'b0); write_bit(1'b0); write_bit(1'b1);
      bus_rep_start();
      write_byte(8'h91, ack);
      check_val("t4_rs_ack", ack, 0);
      read_check("t4_rs_msb", 1'b1);
      read_check("t4_rs_lsb", 1'b0);
      bus_stop();
      wait_clk(10);
      check_val("t4_hits", n_hit - h0, 2);

      // 1-clk glitches on SCL and SDA throughout a read.
      h0 = n_hit; d0 = n_done;
      glitch = 1'b1;
      exp_q.push_back(8'h19);
      exp_q.push_back(8'h20);
      bus_start();
      write_byte(8'h91, ack);
      check_val("t5_addr_ack", ack, 0);
      read_check("t5_msb", 1'b1);
      read_check("t5_lsb", 1'b0);
      glitch = 1'b0;
      bus_stop();
      wait_clk(10);
      check_val("t5_hits", n_hit - h0, 1);
      check_val("t5_dones", n_done - d0, 1);

      // Reset while the slave is pulling SDA low in the LSB.
      exp_q.push_back(8'h19);
      bus_start();
      write_byte(8'h91, ack);
      check_val("t6_addr_ack", ack, 0);
      read_check("t6_msb", 1'b1);
      read_bit(b);
      check_val("t6_lsb_b7", b, 0);
      check_val("t6_driving", bus.sda_pull_s, 1);
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_sda", bus.sda_pull_s, 0);
      check_val("t6_rst_busy", busy, 0);
      check_val("t6_rst_hit", addr_hit, 0);
      check_val("t6_rst_done", xfer_done, 0);
      bus.scl        = 1'b1;
      bus.sda_pull_m = 1'b0;
      wait_clk(5);
      rst_n = 1'b1;
      wait_clk(20);
      check_val("t6_idle_busy", busy, 0);
      temp = 16'h0A80;
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h80);
      bus_start();
      write_byte(8'h91, ack);
      check_val("t6_new_ack", ack, 0);
      read_check("t6_new_msb", 1'b1);
      read_check("t6_new_lsb", 1'b0);
      bus_stop();
      wait_clk(10);
      check_val("t6_busy_after", busy, 0);

      check_val("no_coincide", coincide, 0);
      check_val("queue_drained", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
